// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory stage: peripheral register offsets,
// STATUS bit positions and the address-decode selector.
package dmem_mmio_pkg;

   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CYCLE  = 4'h8;
   localparam logic [3:0] OFF_LED    = 4'hC;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_CNT_LSB = 3;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_TXDATA,
      SEL_STATUS,
      SEL_CYCLE,
      SEL_LED
   } sel_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output; a push is taken
// when full only if a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [AW-1:0]    wr_ptr_next, rd_ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] entry_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign count   = count_reg;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign wr_ptr_next = (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
   assign rd_ptr_next = (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_next;
         if (do_pop)  rd_ptr_reg <= rd_ptr_next;
         count_reg <= count_next;
      end
   end

   // Entries hold no reset; they are only observable through a valid pointer.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] data_reg;
         always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == AW'(gi)))
               data_reg <= din;
         end
         assign entry_q[gi] = data_reg;
      end
   endgenerate

   assign dout = entry_q[rd_ptr_reg];

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory stage: word RAM plus a 16-byte peripheral window holding
// a TX byte FIFO, a loadable cycle counter and an LED register.
module dmem_mmio
   import dmem_mmio_pkg::*;
#(
   parameter int          RAM_WORDS  = 64,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  led
);

   localparam int          RAW       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int          CW        = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS * 4);

   logic [31:0]    word_addr, mmio_off;
   logic [RAW-1:0] ram_idx;
   sel_t           sel;

   logic [31:0] ram_reg [RAM_WORDS];
   logic [31:0] cycle_reg, cycle_next;
   logic [7:0]  led_reg;
   logic        ovf_reg, ovf_next;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
   logic [CW-1:0] fifo_count;
   logic [3:0]    count_ext;
   logic [31:0]   status_word;

   assign word_addr = {addr[31:2], 2'b00};
   assign mmio_off  = word_addr - MMIO_BASE;
   assign ram_idx   = addr[RAW+1:2];

   always_comb begin
      sel = SEL_NONE;
      if (word_addr < RAM_LIMIT) begin
         sel = SEL_RAM;
      end else if (mmio_off[31:4] == 28'd0) begin
         case (mmio_off[3:0])
            OFF_TXDATA: sel = SEL_TXDATA;
            OFF_STATUS: sel = SEL_STATUS;
            OFF_CYCLE:  sel = SEL_CYCLE;
            OFF_LED:    sel = SEL_LED;
            default:    sel = SEL_NONE;
         endcase
      end
   end

   // RAM stores are deliberately not gated by reset.
   always_ff @(posedge clk) begin
      if (memwrite && (sel == SEL_RAM))
         ram_reg[ram_idx] <= writedata;
   end

   assign fifo_push = memwrite && (sel == SEL_TXDATA);
   assign fifo_pop  = tx_valid && tx_ready;
   assign fifo_drop = fifo_push && fifo_full && !fifo_pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (writedata[7:0]),
      .pop   (fifo_pop),
      .dout  (tx_data),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign tx_valid = !fifo_empty;

   always_comb begin
      cycle_next = cycle_reg + 32'd1;
      if (memwrite && (sel == SEL_CYCLE))
         cycle_next = writedata;
   end

   // A dropped push outranks a concurrent clear.
   always_comb begin
      ovf_next = ovf_reg;
      if (fifo_drop)
         ovf_next = 1'b1;
      else if (memwrite && (sel == SEL_STATUS) && writedata[ST_OVF])
         ovf_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_reg <= '0;
         led_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         cycle_reg <= cycle_next;
         ovf_reg   <= ovf_next;
         if (memwrite && (sel == SEL_LED))
            led_reg <= writedata[7:0];
      end
   end

   assign led       = led_reg;
   assign count_ext = 4'(fifo_count);

   always_comb begin
      status_word                      = '0;
      status_word[ST_EMPTY]            = fifo_empty;
      status_word[ST_FULL]             = fifo_full;
      status_word[ST_OVF]              = ovf_reg;
      status_word[ST_CNT_LSB +: 3]     = count_ext[2:0];
   end

   always_comb begin
      readdata = '0;
      case (sel)
         SEL_RAM:    readdata = ram_reg[ram_idx];
         SEL_STATUS: readdata = status_word;
         SEL_CYCLE:  readdata = cycle_reg;
         SEL_LED:    readdata = {24'd0, led_reg};
         default:    readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, decode, TX FIFO, cycle counter, LED
// and reset-during-activity scenarios with hand-computed expectations.
module tb_dmem_mmio;

   localparam logic [31:0] BASE = 32'hFFFF_FF00;
   localparam logic [31:0] A_TX = BASE + 32'h0;
   localparam logic [31:0] A_ST = BASE + 32'h4;
   localparam logic [31:0] A_CY = BASE + 32'h8;
   localparam logic [31:0] A_LD = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  led;

   int total = 0;
   int bad   = 0;

   dmem_mmio #(
      .RAM_WORDS  (64),
      .FIFO_DEPTH (4),
      .MMIO_BASE  (BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .addr      (addr),
      .writedata (writedata),
      .readdata  (readdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .led       (led)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      memwrite  = 1'b1;
      addr      = a;
      writedata = d;
      $display("write addr=%08h data=%08h reset=%0b tx_ready=%0b", a, d, reset, tx_ready);
      step();
      memwrite  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      addr  = A_ST;
      step(); step(); step();
      total++; if (readdata !== 32'h1) begin bad++; $display("FAIL reset_status got=%08h exp=%08h", readdata, 32'h1); end
      total++; if (led !== 8'h00) begin bad++; $display("FAIL reset_led got=%02h exp=00", led); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step();
      addr = A_CY;
      #1;
      $display("read addr=%08h data=%08h", addr, readdata);
      total++; if (readdata !== 32'd5) begin bad++; $display("FAIL reset_cycle got=%08h exp=%08h", readdata, 32'd5); end
   endtask

   task automatic test_ram();
      do_write(32'h10, 32'hDEAD_BEEF);
      addr = 32'h10; #1;
      total++; if (readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_0x10 got=%08h exp=deadbeef", readdata); end
      addr = 32'h13; #1;
      total++; if (readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_0x13 got=%08h exp=deadbeef", readdata); end
      addr = 32'h1_0000; #1;
      total++; if (readdata !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%08h exp=0", readdata); end
      // A store to an unmapped address must not alias onto RAM word 0.
      do_write(32'h0, 32'h0BAD_F00D);
      do_write(32'h1_0000, 32'h1234_5678);
      addr = 32'h0; #1;
      total++; if (readdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL unmapped_write got=%08h exp=0badf00d", readdata); end
   endtask

   task automatic test_fifo_overflow();
      logic [7:0] exp_bytes [4];
      exp_bytes = '{8'h41, 8'h42, 8'h43, 8'h44};
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) do_write(A_TX, 32'h41 + i);
      addr = A_ST; #1;
      total++; if (readdata !== 32'h26) begin bad++; $display("FAIL ovf_status got=%08h exp=00000026", readdata); end
      step();
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin bad++; $display("FAIL head_hold valid=%0b data=%02h exp valid=1 data=41", tx_valid, tx_data); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         $display("pop tx_valid=%0b tx_data=%02h", tx_valid, tx_data);
         total++; if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) begin bad++; $display("FAIL drain_%0d valid=%0b data=%02h exp valid=1 data=%02h", i, tx_valid, tx_data, exp_bytes[i]); end
         step();
      end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b exp=0", tx_valid); end
      tx_ready = 1'b0;
      addr = A_ST; #1;
      total++; if (readdata !== 32'h5) begin bad++; $display("FAIL ovf_sticky got=%08h exp=00000005", readdata); end
      do_write(A_ST, 32'h4);
      addr = A_ST; #1;
      total++; if (readdata !== 32'h1) begin bad++; $display("FAIL ovf_clear got=%08h exp=00000001", readdata); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_bytes [4];
      exp_bytes = '{8'h51, 8'h52, 8'h53, 8'h55};
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) do_write(A_TX, 32'h50 + i);
      tx_ready = 1'b1;
      do_write(A_TX, 32'h55);
      tx_ready = 1'b0;
      addr = A_ST; #1;
      total++; if (readdata !== 32'h22) begin bad++; $display("FAIL full_push_pop got=%08h exp=00000022", readdata); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         $display("pop tx_valid=%0b tx_data=%02h", tx_valid, tx_data);
         total++; if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) begin bad++; $display("FAIL order_%0d valid=%0b data=%02h exp valid=1 data=%02h", i, tx_valid, tx_data, exp_bytes[i]); end
         step();
      end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL order_empty got=%0b exp=0", tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_cycle_led();
      logic [31:0] exp_cy [3];
      exp_cy = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
      do_write(A_CY, 32'hFFFF_FFFE);
      addr = A_CY;
      for (int i = 0; i < 3; i++) begin
         #1;
         $display("read addr=%08h data=%08h", addr, readdata);
         total++; if (readdata !== exp_cy[i]) begin bad++; $display("FAIL cycle_%0d got=%08h exp=%08h", i, readdata, exp_cy[i]); end
         step();
      end
      do_write(A_LD, 32'h1A5);
      addr = A_LD; #1;
      total++; if (led !== 8'hA5) begin bad++; $display("FAIL led_port got=%02h exp=a5", led); end
      total++; if (readdata !== 32'hA5) begin bad++; $display("FAIL led_read got=%08h exp=000000a5", readdata); end
   endtask

   task automatic test_reset_mid();
      tx_ready = 1'b0;
      do_write(A_TX, 32'h61);
      do_write(A_TX, 32'h62);
      reset = 1'b1;
      do_write(A_TX, 32'h63);
      reset = 1'b0;
      addr = A_ST; #1;
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b exp=0", tx_valid); end
      total++; if (readdata !== 32'h1) begin bad++; $display("FAIL rst_mid_status got=%08h exp=00000001", readdata); end
      total++; if (led !== 8'h00) begin bad++; $display("FAIL rst_mid_led got=%02h exp=00", led); end
      reset = 1'b1;
      do_write(32'h20, 32'hCAFE_F00D);
      reset = 1'b0;
      addr = 32'h20; #1;
      total++; if (readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rst_ram_store got=%08h exp=cafef00d", readdata); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_fifo_overflow();
      test_back_to_back();
      test_cycle_led();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
